bus_interface_unit: RTL and testbench
=====================================

// Module: bus_interface_unit
// PURPOSE
//  Memory-side responder to the instruction decoder's bus requests. Owns the program counter,
//  the address-bus mux, the input data latch (IDL) and the data output register (DOR).
//  Runs the reset-vector fetch, then serves opcode/operand reads and store cycles.
//  Sits between the external 6502 pins and the decoder/ALU datapath.
// PARAMETERS
//  RESET_VECTOR  16'hFFFC  address of vector low byte; high byte read from RESET_VECTOR+1
//  NOP_OPCODE    8'hEA     opcode presented on instruction while not in RUN
// PORTS
//  clk                 in   1   core clock; all state on rising edge
//  res                 in   1   reset, asynchronous, active-high
//  rdy                 in   1   external ready; 0 stalls read cycles
//  pc_enable           in   1   decoder: increment PC this cycle
//  address_select      in   1   decoder: 1 = drive memory_address, 0 = drive PC
//  memory_address      in   16  decoder-supplied operand address
//  rw                  in   1   decoder: 1 read, 0 write
//  data_buffer_enable  in   2   DOR op: 00 IDLE, 01 LOAD, 10 STORE (11 = IDLE)
//  input_data_latch_enable in 2 IDL op: 00 IDLE, 01 LOAD, 10 STORE (11 = IDLE)
//  alu_result          in   8   internal bus value captured by DOR LOAD
//  data_in             in   8   external data bus, read direction
//  address_bus         out  16  external address pins
//  rw_pin              out  1   external R/W (1 read)
//  data_out            out  8   external data bus, write direction
//  data_oe             out  1   1 = drive data_out onto the pins
//  instruction         out  8   byte to decoder (data_in in RUN, NOP_OPCODE otherwise)
//  idl_data            out  8   IDL contents onto internal bus
//  idl_valid           out  1   1 while IDL STORE is requested
//  core_rdy            out  1   rdy to decoder: rdy & (state==RUN)
// BEHAVIOUR
//  Reset (async): state=RST_LO, PC=16'h0000, IDL=8'h00, DOR=8'h00; outputs: address_bus=RESET_VECTOR,
//   rw_pin=1, data_oe=0, data_out=8'h00, instruction=NOP_OPCODE, idl_valid=0, core_rdy=0.
//  FSM RST_LO -> RST_HI -> RUN; each transition only on a clk edge with rdy=1.
//   RST_LO: address_bus=RESET_VECTOR, read; on advance PC[7:0]<=data_in.
//   RST_HI: address_bus=RESET_VECTOR+1, read; on advance PC[15:8]<=data_in.
//   RUN: terminal until res. First RUN cycle addresses the fetched vector.
//  RUN address mux (combinational): address_bus = address_select ? memory_address : PC.
//  rw_pin = rw in RUN, 1 otherwise. data_oe = (state==RUN) & ~rw; data_out = DOR always.
//  PC: +1 mod 2^16 (16'hFFFF -> 16'h0000) when RUN & pc_enable & rdy; pc_enable ignored outside RUN.
//  IDL LOAD: IDL<=data_in at edge when RUN & rdy. IDL STORE: idl_valid=1, idl_data=IDL (comb).
//  DOR LOAD: DOR<=alu_result at edge when RUN (write path; not gated by rdy).
//  rdy=0: read cycles stall; PC, IDL, FSM hold. A write cycle (rw=0) still completes; DOR ops apply.
//  DOR LOAD and rw=0 same cycle: pins show old DOR; new value visible next cycle.
//  IDL LOAD and STORE cannot coincide (single 2-bit code). Enable code 11 treated as IDLE.
//  res mid-operation: immediate return to reset values incl. data_oe=0 same instant; vector refetched.
//  idl_data = IDL regardless of enable; consumers qualify with idl_valid.
// STRUCTURE
//  Shared include: BUF_IDLE/BUF_LOAD/BUF_STORE 2-bit codes, NOP opcode, RESET_VECTOR
//   constant (also used by instruction_decode).
//  One sub-module natural: program_counter (16-bit load-low/load-high/increment, wraps).
//  FSM, address mux, IDL and DOR stay in this module.
// TESTING
//  Reset vector: mem[FFFC]=34, mem[FFFD]=12, rdy=1 -> addr FFFC,FFFD then 1234; core_rdy=1 from cycle 3.
//  rdy stall: rdy=0 during RST_HI for 3 cycles -> addr holds FFFD, PC high not loaded, then 1234.
//  PC wrap: PC=FFFF, pc_enable=1, address_select=0 -> next address_bus=0000.
//  Zero-page read: address_select=1, memory_address=0042, mem=0x80, IDL LOAD then STORE -> idl_data=80, idl_valid=1.
//  Store: DOR LOAD alu_result=5A, next cycle rw=0, address_select=1, addr 0042 -> data_oe=1, data_out=5A, rw_pin=0.
//  Async res asserted mid-write (between edges) -> data_oe=0, address_bus=FFFC at once; vector refetched.

Source files
------------

// File: rtl/bus_interface_unit_pkg.sv
// Shared definitions for the bus interface unit and its neighbours
// (instruction_decode uses the same buffer-op codes and reset vector).
//   BUF_IDLE / BUF_LOAD / BUF_STORE : 2-bit op codes for the IDL and DOR
//                                     enables (code 2'b11 behaves as IDLE)
//   NOP_OPCODE_DEF                  : opcode shown to the decoder outside RUN
//   RESET_VECTOR_DEF                : address of the reset vector low byte
//   biu_state_t                     : bus-unit sequencing state
//   biu_debug_t                     : snapshot of internal state for observation
package bus_interface_unit_pkg;

    localparam logic [1:0]  BUF_IDLE  = 2'b00;
    localparam logic [1:0]  BUF_LOAD  = 2'b01;
    localparam logic [1:0]  BUF_STORE = 2'b10;

    localparam logic [7:0]  NOP_OPCODE_DEF   = 8'hEA;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'hFFFC;

    typedef enum logic [1:0] {
        ST_RST_LO = 2'd0,
        ST_RST_HI = 2'd1,
        ST_RUN    = 2'd2
    } biu_state_t;

    typedef struct packed {
        biu_state_t  state;
        logic [15:0] pc;
        logic [7:0]  idl;
        logic [7:0]  dor;
    } biu_debug_t;

endpackage

// File: rtl/bus_interface_unit_program_counter.sv
// 16-bit program counter with byte-wise load and wrapping increment.
// Ports:
//   clk      in   core clock
//   rst      in   asynchronous active-high reset, clears the count to 0
//   load_lo  in   load data into pc[7:0]
//   load_hi  in   load data into pc[15:8]
//   inc      in   increment pc, 16'hFFFF wraps to 16'h0000
//   data     in   byte to load
//   pc       out  current program counter
// The three controls are mutually exclusive in normal use; the priority
// below only decides the outcome if more than one is raised.
module bus_interface_unit_program_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic        inc,
    input  logic [7:0]  data,
    output logic [15:0] pc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= 16'h0000;
        end else if (load_lo) begin
            pc[7:0] <= data;
        end else if (load_hi) begin
            pc[15:8] <= data;
        end else if (inc) begin
            pc <= pc + 16'd1;
        end
    end

endmodule

// File: rtl/bus_interface_unit.sv
// Memory-side responder to the instruction decoder's bus requests.
// Fetches the reset vector, then drives opcode/operand reads and store
// cycles. Owns the address mux, the input data latch (IDL) and the data
// output register (DOR); the program counter is a sub-module.
// Ports:
//   clk, res                 clock; asynchronous active-high reset
//   rdy                      external ready, 0 stalls read cycles
//   pc_enable                increment PC this cycle (RUN only)
//   address_select           1 = memory_address on the bus, 0 = PC
//   memory_address           decoder-supplied operand address
//   rw                       1 read, 0 write
//   data_buffer_enable       DOR op code
//   input_data_latch_enable  IDL op code
//   alu_result               value captured by DOR LOAD
//   data_in                  external data bus (read direction)
//   address_bus, rw_pin      external address and R/W pins
//   data_out, data_oe        external data bus (write direction) and enable
//   instruction              byte to the decoder (NOP outside RUN)
//   idl_data, idl_valid      IDL contents and STORE request qualifier
//   core_rdy                 rdy forwarded to the decoder while in RUN
//   debug                    internal state snapshot
//
// Ready handshake: a read cycle completes only on a rising edge with
// rdy=1; with rdy=0 the address, PC, IDL and sequencing state all hold and
// the cycle repeats. Write cycles (rw=0) are not stalled: the pins carry
// DOR for the whole cycle and DOR updates on every edge it is loaded.
module bus_interface_unit
    import bus_interface_unit_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [7:0]  NOP_OPCODE   = NOP_OPCODE_DEF
) (
    input  logic        clk,
    input  logic        res,
    input  logic        rdy,
    input  logic        pc_enable,
    input  logic        address_select,
    input  logic [15:0] memory_address,
    input  logic        rw,
    input  logic [1:0]  data_buffer_enable,
    input  logic [1:0]  input_data_latch_enable,
    input  logic [7:0]  alu_result,
    input  logic [7:0]  data_in,
    output logic [15:0] address_bus,
    output logic        rw_pin,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic [7:0]  instruction,
    output logic [7:0]  idl_data,
    output logic        idl_valid,
    output logic        core_rdy,
    output biu_debug_t  debug
);

    localparam logic [15:0] RESET_VECTOR_HI = RESET_VECTOR + 16'd1;

    biu_state_t  state;
    biu_state_t  state_next;
    logic [15:0] pc;
    logic [7:0]  idl;
    logic [7:0]  dor;
    logic        in_run;

    assign in_run = (state == ST_RUN);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= ST_RST_LO;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    // Vector fetch steps only on completed (rdy=1) read cycles; RUN is
    // left only through res.
    always_comb begin
        state_next = state;
        case (state)
            ST_RST_LO: if (rdy) state_next = ST_RST_HI;
            ST_RST_HI: if (rdy) state_next = ST_RUN;
            ST_RUN:    state_next = ST_RUN;
            default:   state_next = ST_RST_LO;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        address_bus = RESET_VECTOR;
        rw_pin      = 1'b1;
        data_oe     = 1'b0;
        instruction = NOP_OPCODE;
        idl_valid   = 1'b0;
        core_rdy    = 1'b0;
        case (state)
            ST_RST_LO: address_bus = RESET_VECTOR;
            ST_RST_HI: address_bus = RESET_VECTOR_HI;
            ST_RUN: begin
                address_bus = address_select ? memory_address : pc;
                rw_pin      = rw;
                data_oe     = ~rw;
                instruction = data_in;
                idl_valid   = (input_data_latch_enable == BUF_STORE);
                core_rdy    = rdy;
            end
            default: address_bus = RESET_VECTOR;
        endcase
    end

    // DOR drives the pins unconditionally; data_oe decides whether the
    // pad actually drives, so a same-cycle LOAD shows up one cycle later.
    assign data_out = dor;
    assign idl_data = idl;

    // ---------------- program counter ----------------
    bus_interface_unit_program_counter u_pc (
        .clk     (clk),
        .rst     (res),
        .load_lo (state == ST_RST_LO && rdy),
        .load_hi (state == ST_RST_HI && rdy),
        .inc     (in_run && pc_enable && rdy),
        .data    (data_in),
        .pc      (pc)
    );

    // ---------------- input data latch ----------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            idl <= 8'h00;
        end else if (in_run && rdy && input_data_latch_enable == BUF_LOAD) begin
            idl <= data_in;
        end
    end

    // ---------------- data output register ----------------
    // Write path: not gated by rdy so a stalled bus still takes the store.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            dor <= 8'h00;
        end else if (in_run && data_buffer_enable == BUF_LOAD) begin
            dor <= alu_result;
        end
    end

    assign debug = '{state: state, pc: pc, idl: idl, dor: dor};

endmodule

// File: tb/tb_bus_interface_unit.sv
module tb_bus_interface_unit;
    import bus_interface_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    logic        rdy;
    logic        pc_enable;
    logic        address_select;
    logic [15:0] memory_address;
    logic        rw;
    logic [1:0]  data_buffer_enable;
    logic [1:0]  input_data_latch_enable;
    logic [7:0]  alu_result;
    logic [7:0]  data_in;
    logic [15:0] address_bus;
    logic        rw_pin;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [7:0]  instruction;
    logic [7:0]  idl_data;
    logic        idl_valid;
    logic        core_rdy;
    biu_debug_t  debug;

    bus_interface_unit dut (
        .clk                     (clk),
        .res                     (res),
        .rdy                     (rdy),
        .pc_enable               (pc_enable),
        .address_select          (address_select),
        .memory_address          (memory_address),
        .rw                      (rw),
        .data_buffer_enable      (data_buffer_enable),
        .input_data_latch_enable (input_data_latch_enable),
        .alu_result              (alu_result),
        .data_in                 (data_in),
        .address_bus             (address_bus),
        .rw_pin                  (rw_pin),
        .data_out                (data_out),
        .data_oe                 (data_oe),
        .instruction             (instruction),
        .idl_data                (idl_data),
        .idl_valid               (idl_valid),
        .core_rdy                (core_rdy),
        .debug                   (debug)
    );

    // ---------------- memory model ----------------
    logic [7:0] mem [0:65535];
    assign data_in = mem[address_bus];

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        sel;
        logic [15:0] maddr;
        logic        pc_en;
        logic        rw;
        logic [1:0]  dor_en;
        logic [1:0]  idl_en;
        logic [7:0]  alu;
        logic        rdy;
        logic [15:0] e_addr;
        logic        e_rwp;
        logic        e_oe;
        logic [7:0]  e_dout;
        logic [7:0]  e_instr;
        logic        e_ivalid;
        logic [7:0]  e_idata;
        logic        e_crdy;
    } vec_t;

    // ---------------- driver ----------------
    // Called at a falling edge: drives inputs, checks outputs 1 ns later,
    // then waits for the next falling edge (one rising edge in between).
    task automatic apply(input string tag, input vec_t v);
        address_select          = v.sel;
        memory_address          = v.maddr;
        pc_enable               = v.pc_en;
        rw                      = v.rw;
        data_buffer_enable      = v.dor_en;
        input_data_latch_enable = v.idl_en;
        alu_result              = v.alu;
        rdy                     = v.rdy;
        #1;
        chk({tag, ".addr"},      address_bus,        v.e_addr);
        chk({tag, ".rw_pin"},    16'(rw_pin),        16'(v.e_rwp));
        chk({tag, ".data_oe"},   16'(data_oe),       16'(v.e_oe));
        chk({tag, ".data_out"},  16'(data_out),      16'(v.e_dout));
        chk({tag, ".instr"},     16'(instruction),   16'(v.e_instr));
        chk({tag, ".idl_valid"}, 16'(idl_valid),     16'(v.e_ivalid));
        chk({tag, ".idl_data"},  16'(idl_data),      16'(v.e_idata));
        chk({tag, ".core_rdy"},  16'(core_rdy),      16'(v.e_crdy));
        @(negedge clk);
    endtask

    // Reset held across one rising edge, released at a falling edge.
    task automatic do_reset(input string tag);
        res = 1'b1;
        apply(tag, '{1'b0, 16'h0000, 1'b0, 1'b1, BUF_IDLE, BUF_IDLE, 8'h00, 1'b1,
                     16'hFFFC, 1'b1, 1'b0, 8'h00, 8'hEA, 1'b0, 8'h00, 1'b0});
        res = 1'b0;
    endtask

    vec_t idle_lo, idle_hi;
    vec_t tbl [12];

    initial begin
        // Vectors for the RUN phase, starting with PC=1234, IDL=00, DOR=00.
        //           sel  maddr     pc  rw  dor        idl        alu    rdy   addr      rwp oe  dout   instr  iv  idata  crdy
        tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1, BUF_IDLE, BUF_IDLE,  8'h00, 1'b1, 16'h1234, 1'b1, 1'b0, 8'h00, 8'hA9, 1'b0, 8'h00, 1'b1};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, BUF_IDLE, BUF_IDLE,  8'h00, 1'b0, 16'h1235, 1'b1, 1'b0, 8'h00, 8'h05, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, BUF_IDLE, BUF_IDLE,  8'h00, 1'b1, 16'h1235, 1'b1, 1'b0, 8'h00, 8'h05, 1'b0, 8'h00, 1'b1};
        tbl[3]  = '{1'b1, 16'h0042, 1'b0, 1'b1, BUF_IDLE, BUF_LOAD,  8'h00, 1'b1, 16'h0042, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[4]  = '{1'b1, 16'h0042, 1'b0, 1'b1, BUF_IDLE, BUF_STORE, 8'h00, 1'b1, 16'h0042, 1'b1, 1'b0, 8'h00, 8'h80, 1'b1, 8'h80, 1'b1};
        tbl[5]  = '{1'b1, 16'h0043, 1'b0, 1'b1, BUF_LOAD, BUF_IDLE,  8'h5A, 1'b1, 16'h0043, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h80, 1'b1};
        tbl[6]  = '{1'b1, 16'h0042, 1'b0, 1'b0, BUF_LOAD, BUF_IDLE,  8'hC3, 1'b1, 16'h0042, 1'b0, 1'b1, 8'h5A, 8'h80, 1'b0, 8'h80, 1'b1};
        tbl[7]  = '{1'b1, 16'h0044, 1'b0, 1'b0, BUF_LOAD, BUF_IDLE,  8'h11, 1'b0, 16'h0044, 1'b0, 1'b1, 8'hC3, 8'h00, 1'b0, 8'h80, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, BUF_IDLE, 2'b11,     8'h00, 1'b1, 16'h1235, 1'b1, 1'b0, 8'h11, 8'h05, 1'b0, 8'h80, 1'b1};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, BUF_IDLE, BUF_STORE, 8'h00, 1'b1, 16'h1235, 1'b1, 1'b0, 8'h11, 8'h05, 1'b1, 8'h80, 1'b1};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, BUF_IDLE, BUF_LOAD,  8'h00, 1'b0, 16'h1235, 1'b1, 1'b0, 8'h11, 8'h05, 1'b0, 8'h80, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, BUF_IDLE, BUF_STORE, 8'h00, 1'b1, 16'h1235, 1'b1, 1'b0, 8'h11, 8'h05, 1'b1, 8'h80, 1'b1};

        idle_lo = '{1'b0, 16'h0000, 1'b0, 1'b1, BUF_IDLE, BUF_IDLE, 8'h00, 1'b1,
                    16'hFFFC, 1'b1, 1'b0, 8'h00, 8'hEA, 1'b0, 8'h00, 1'b0};
        idle_hi = '{1'b0, 16'h0000, 1'b0, 1'b1, BUF_IDLE, BUF_IDLE, 8'h00, 1'b1,
                    16'hFFFD, 1'b1, 1'b0, 8'h00, 8'hEA, 1'b0, 8'h00, 1'b0};

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        mem[16'h1234] = 8'hA9;
        mem[16'h1235] = 8'h05;
        mem[16'h0042] = 8'h80;
        mem[16'hFFFF] = 8'h4C;

        address_select = 1'b0; memory_address = 16'h0000; pc_enable = 1'b0;
        rw = 1'b1; data_buffer_enable = BUF_IDLE; input_data_latch_enable = BUF_IDLE;
        alu_result = 8'h00; rdy = 1'b1;

        // ---- reset state and vector fetch (rw=0 ignored outside RUN) ----
        @(negedge clk);
        do_reset("reset");
        apply("fetch_lo", '{1'b0, 16'h0000, 1'b0, 1'b0, BUF_LOAD, BUF_LOAD, 8'h77, 1'b1,
                            16'hFFFC, 1'b1, 1'b0, 8'h00, 8'hEA, 1'b0, 8'h00, 1'b0});
        apply("fetch_hi", idle_hi);

        // ---- table-driven RUN vectors ----
        for (int i = 0; i < 12; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // ---- rdy stall during the high-byte fetch ----
        do_reset("stall_rst");
        apply("stall_lo", idle_lo);
        for (int k = 0; k < 3; k++) begin
            vec_t s;
            s = idle_hi;
            s.rdy = 1'b0;
            apply($sformatf("stall_hi%0d", k), s);
        end
        apply("stall_go", idle_hi);
        apply("stall_run", '{1'b0, 16'h0000, 1'b0, 1'b1, BUF_IDLE, BUF_IDLE, 8'h00, 1'b1,
                             16'h1234, 1'b1, 1'b0, 8'h00, 8'hA9, 1'b0, 8'h00, 1'b1});

        // ---- PC wrap via a vector of FFFF ----
        mem[16'hFFFC] = 8'hFF;
        mem[16'hFFFD] = 8'hFF;
        do_reset("wrap_rst");
        apply("wrap_lo", idle_lo);
        apply("wrap_hi", idle_hi);
        apply("wrap_ffff", '{1'b0, 16'h0000, 1'b1, 1'b1, BUF_IDLE, BUF_IDLE, 8'h00, 1'b1,
                             16'hFFFF, 1'b1, 1'b0, 8'h00, 8'h4C, 1'b0, 8'h00, 1'b1});
        apply("wrap_0000", '{1'b0, 16'h0000, 1'b0, 1'b1, BUF_IDLE, BUF_IDLE, 8'h00, 1'b1,
                             16'h0000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1});

        // ---- async reset in the middle of a write cycle ----
        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        apply("pre_wr", '{1'b1, 16'h0042, 1'b0, 1'b1, BUF_LOAD, BUF_IDLE, 8'hA5, 1'b1,
                          16'h0042, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0, 8'h00, 1'b1});
        address_select = 1'b1; memory_address = 16'h0042; rw = 1'b0;
        data_buffer_enable = BUF_IDLE;
        #1;
        chk("wr.data_oe",  16'(data_oe),  16'h0001);
        chk("wr.data_out", 16'(data_out), 16'h00A5);
        chk("wr.rw_pin",   16'(rw_pin),   16'h0000);
        #1;
        res = 1'b1;
        #1;
        chk("async.data_oe",  16'(data_oe),     16'h0000);
        chk("async.addr",     address_bus,      16'hFFFC);
        chk("async.rw_pin",   16'(rw_pin),      16'h0001);
        chk("async.data_out", 16'(data_out),    16'h0000);
        chk("async.instr",    16'(instruction), 16'h00EA);
        chk("async.core_rdy", 16'(core_rdy),    16'h0000);
        @(negedge clk);
        res = 1'b0;
        apply("refetch_lo", idle_lo);
        apply("refetch_hi", idle_hi);
        apply("refetch_run", '{1'b0, 16'h0000, 1'b0, 1'b1, BUF_IDLE, BUF_IDLE, 8'h00, 1'b1,
                               16'h1234, 1'b1, 1'b0, 8'h00, 8'hA9, 1'b0, 8'h00, 1'b1});

        // ---- report ----
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
